// File: rtl/hopfield_assoc_mem_if.sv
// Request/status bundle of the Hopfield associative memory core.
// Signal suffixes are from the core's point of view: the core takes the slave modport.
interface hopfield_assoc_mem_if #(
    parameter int N = 25
);
    logic         clear_i;
    logic         learn_valid_i;
    logic         learn_ready_o;
    logic [N-1:0] learn_pattern_i;
    logic         recall_start_i;
    logic [N-1:0] recall_seed_i;
    logic         busy_o;
    logic         done_o;
    logic         converged_o;
    logic [N-1:0] state_out_o;
    logic [3:0]   sweeps_o;

    modport slave (
        input  clear_i, learn_valid_i, learn_pattern_i, recall_start_i, recall_seed_i,
        output learn_ready_o, busy_o, done_o, converged_o, state_out_o, sweeps_o
    );

    modport master (
        output clear_i, learn_valid_i, learn_pattern_i, recall_start_i, recall_seed_i,
        input  learn_ready_o, busy_o, done_o, converged_o, state_out_o, sweeps_o
    );
endinterface

// File: rtl/hopfield_assoc_mem.sv
// Hopfield associative memory: online Hebbian learning, iterative recall to a fixed point.
// Define HOPFIELD_SYNC_UPDATE_EN for parallel (one sweep per cycle) recall; default is sequential.
module hopfield_assoc_mem #(
    parameter int N          = 25,
    parameter int WW         = 4,
    parameter int SW         = WW + $clog2(N) + 1,
    parameter int MAX_SWEEPS = 8
) (
    input  logic                clk,
    input  logic                rst,
    hopfield_assoc_mem_if.slave bus
);
    localparam int                      KW          = $clog2(N);
    localparam int                      WMAX_I      = (1 << (WW - 1)) - 1;
    localparam logic signed [WW-1:0]    W_MAX       = WW'(WMAX_I);
    localparam logic signed [WW-1:0]    W_MIN       = WW'(-WMAX_I);
    localparam logic signed [WW-1:0]    W_ONE       = WW'(1);
    localparam logic signed [SW-1:0]    SUM_ZERO    = SW'(0);
    localparam logic [KW-1:0]           K_LAST      = KW'(N - 1);
    localparam logic [3:0]              SWEEP_LIMIT = 4'(MAX_SWEEPS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LEARN  = 3'd2,
        ST_RECALL = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [KW-1:0]        row_q, row_d;
    logic [N-1:0]         pat_q, pat_d;
    logic [N-1:0]         s_q, s_d;
    logic [3:0]           sweep_q, sweep_d;
    logic [3:0]           sweeps_q, sweeps_d;
    logic                 conv_q, conv_d;
    logic                 done_q, busy_q, ready_q;
    logic signed [WW-1:0] w_q [N][N];
    logic signed [WW-1:0] w_d [N][N];

    function automatic logic signed [WW-1:0] sat_step(input logic signed [WW-1:0] w,
                                                      input logic                 up);
        logic signed [WW-1:0] r;
        if (up) r = (w == W_MAX) ? w : w + W_ONE;
        else    r = (w == W_MIN) ? w : w - W_ONE;
        return r;
    endfunction

`ifndef HOPFIELD_SYNC_UPDATE_EN
    logic                 changed_q, changed_d;
    logic signed [SW-1:0] sum_s;
    logic                 new_bit_s;
    logic                 flip_s;

    // Single adder tree: local field of neuron row_q; a zero field keeps the old state.
    always_comb begin
        sum_s = SUM_ZERO;
        for (int j = 0; j < N; j++) begin
            if (s_q[j]) sum_s = sum_s + SW'(w_q[row_q][j]);
            else        sum_s = sum_s - SW'(w_q[row_q][j]);
        end
        if (sum_s > SUM_ZERO)      new_bit_s = 1'b1;
        else if (sum_s < SUM_ZERO) new_bit_s = 1'b0;
        else                       new_bit_s = s_q[row_q];
        flip_s = (new_bit_s != s_q[row_q]);
    end
`else
    logic [N-1:0] prev_q, prev_d;
    logic [N-1:0] s_sync_s;

    // N adder trees: every neuron's next value from the same snapshot of s_q.
    always_comb begin
        logic signed [SW-1:0] acc;
        s_sync_s = s_q;
        for (int k = 0; k < N; k++) begin
            acc = SUM_ZERO;
            for (int j = 0; j < N; j++) begin
                if (s_q[j]) acc = acc + SW'(w_q[k][j]);
                else        acc = acc - SW'(w_q[k][j]);
            end
            if (acc > SUM_ZERO)      s_sync_s[k] = 1'b1;
            else if (acc < SUM_ZERO) s_sync_s[k] = 1'b0;
            else                     s_sync_s[k] = s_q[k];
        end
    end
`endif

    // Control FSM next state and datapath next values.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        pat_d    = pat_q;
        s_d      = s_q;
        sweep_d  = sweep_q;
        sweeps_d = sweeps_q;
        conv_d   = conv_q;
`ifndef HOPFIELD_SYNC_UPDATE_EN
        changed_d = changed_q;
`else
        prev_d    = prev_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.clear_i) begin
                    state_d = ST_CLEAR;
                    row_d   = '0;
                end else if (bus.learn_valid_i) begin
                    state_d = ST_LEARN;
                    row_d   = '0;
                    pat_d   = bus.learn_pattern_i;
                end else if (bus.recall_start_i) begin
                    state_d = ST_RECALL;
                    row_d   = '0;
                    s_d     = bus.recall_seed_i;
                    sweep_d = 4'd0;
                    conv_d  = 1'b0;
`ifndef HOPFIELD_SYNC_UPDATE_EN
                    changed_d = 1'b0;
`else
                    prev_d    = bus.recall_seed_i;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR, ST_LEARN: begin
                if (row_q == K_LAST) begin
                    state_d = ST_IDLE;
                    row_d   = '0;
                end else begin
                    row_d = row_q + KW'(1);
                end
            end
            ST_RECALL: begin
`ifndef HOPFIELD_SYNC_UPDATE_EN
                s_d[row_q] = new_bit_s;
                if (row_q == K_LAST) begin
                    row_d    = '0;
                    sweeps_d = sweep_q + 4'd1;
                    if (!(changed_q | flip_s)) begin
                        conv_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (sweep_q + 4'd1 == SWEEP_LIMIT) begin
                        conv_d  = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        sweep_d   = sweep_q + 4'd1;
                        changed_d = 1'b0;
                    end
                end else begin
                    row_d     = row_q + KW'(1);
                    changed_d = changed_q | flip_s;
                end
`else
                s_d      = s_sync_s;
                prev_d   = s_q;
                sweeps_d = sweep_q + 4'd1;
                if (s_sync_s == s_q) begin
                    conv_d  = 1'b1;
                    state_d = ST_DONE;
                end else if ((sweep_q != 4'd0) && (s_sync_s == prev_q)) begin
                    // Period-2 oscillation never settles under parallel update.
                    conv_d  = 1'b0;
                    state_d = ST_DONE;
                end else if (sweep_q + 4'd1 == SWEEP_LIMIT) begin
                    conv_d  = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    sweep_d = sweep_q + 4'd1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Weight array: CLEAR zeroes row row_q, LEARN applies the Hebbian step to row row_q.
    always_comb begin
        w_d = w_q;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if ((state_q == ST_CLEAR) && (row_q == KW'(i))) begin
                    w_d[i][j] = '0;
                end else if ((state_q == ST_LEARN) && (row_q == KW'(i)) && (i != j)) begin
                    w_d[i][j] = sat_step(w_q[i][j], pat_q[i] == pat_q[j]);
                end else begin
                    w_d[i][j] = w_q[i][j];
                end
            end
        end
    end

    // State and output registers; status flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            pat_q    <= '0;
            s_q      <= '0;
            sweep_q  <= 4'd0;
            sweeps_q <= 4'd0;
            conv_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            w_q      <= '{default: '0};
`ifndef HOPFIELD_SYNC_UPDATE_EN
            changed_q <= 1'b0;
`else
            prev_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            pat_q    <= pat_d;
            s_q      <= s_d;
            sweep_q  <= sweep_d;
            sweeps_q <= sweeps_d;
            conv_q   <= conv_d;
            done_q   <= (state_d == ST_DONE);
            busy_q   <= (state_d != ST_IDLE);
            ready_q  <= (state_d == ST_IDLE);
            w_q      <= w_d;
`ifndef HOPFIELD_SYNC_UPDATE_EN
            changed_q <= changed_d;
`else
            prev_q    <= prev_d;
`endif
        end
    end

    assign bus.learn_ready_o = ready_q;
    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
    assign bus.converged_o   = conv_q;
    assign bus.state_out_o   = s_q;
    assign bus.sweeps_o      = sweeps_q;
endmodule

// File: tb/tb_hopfield_assoc_mem.sv
// Self-checking bench for hopfield_assoc_mem: vector table, recall scoreboard and a
// behavioural Hopfield reference model, plus hand-written reset/priority/abort sequences.
module tb_hopfield_assoc_mem;
    localparam int N          = 25;
    localparam int WW         = 4;
    localparam int MAX_SWEEPS = 8;
    localparam int WLIM       = 7;
    localparam logic [N-1:0] PAT_D = 25'h0E94A4F;
    localparam logic [N-1:0] PAT_C = 25'h0F8420F;
    localparam logic [N-1:0] PAT_J = 25'h1F1084C;
    localparam logic [N-1:0] PAT_M = 25'h118EB71;
    localparam logic [N-1:0] D_NOISY = 25'h0E94ACE;

    logic clk = 1'b0;
    logic rst = 1'b0;

    hopfield_assoc_mem_if #(.N(N)) bus();

    hopfield_assoc_mem #(.N(N), .WW(WW), .MAX_SWEEPS(MAX_SWEEPS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {OP_CLR, OP_LRN, OP_RCL} op_e;
    typedef struct {
        op_e          op;
        logic [N-1:0] data;
        logic         use_model;
        logic [N-1:0] exp_st;
        logic         exp_conv;
        logic [3:0]   exp_sw;
    } vec_t;
    typedef struct {
        logic [N-1:0] st;
        logic         conv;
        logic [3:0]   sw;
        int           lat;
    } exp_t;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           mw [N][N];
    exp_t         sb_q [$];
    logic [N-1:0] last_state;
    vec_t         vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic int recall_latency(input int sw);
`ifdef HOPFIELD_SYNC_UPDATE_EN
        return sw + 1;
`else
        return N * sw + 1;
`endif
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) mw[i][j] = 0;
    endtask

    task automatic model_learn(input logic [N-1:0] p);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (i != j) begin
                    if (p[i] == p[j]) mw[i][j] = (mw[i][j] >= WLIM) ? WLIM : mw[i][j] + 1;
                    else              mw[i][j] = (mw[i][j] <= -WLIM) ? -WLIM : mw[i][j] - 1;
                end
    endtask

    function automatic logic field_bit(input logic [N-1:0] s, input int k);
        int sum = 0;
        for (int j = 0; j < N; j++) sum += s[j] ? mw[k][j] : -mw[k][j];
        if (sum > 0) return 1'b1;
        if (sum < 0) return 1'b0;
        return s[k];
    endfunction

    task automatic model_recall(input logic [N-1:0] seed, output exp_t e);
        logic [N-1:0] s, old_s, prev_s, nxt;
        logic         fin, chg;
        s = seed; prev_s = seed; fin = 1'b0;
        e.conv = 1'b0; e.sw = 4'(MAX_SWEEPS);
        for (int t = 1; t <= MAX_SWEEPS; t++) begin
            if (!fin) begin
                old_s = s;
`ifdef HOPFIELD_SYNC_UPDATE_EN
                for (int k = 0; k < N; k++) nxt[k] = field_bit(old_s, k);
                s = nxt;
                chg = (s != old_s);
                if (!chg) begin e.conv = 1'b1; e.sw = 4'(t); fin = 1'b1; end
                else if (t > 1 && s == prev_s) begin e.conv = 1'b0; e.sw = 4'(t); fin = 1'b1; end
                prev_s = old_s;
`else
                for (int k = 0; k < N; k++) s[k] = field_bit(s, k);
                chg = (s != old_s);
                if (!chg) begin e.conv = 1'b1; e.sw = 4'(t); fin = 1'b1; end
`endif
            end
        end
        e.st  = s;
        e.lat = recall_latency(int'(e.sw));
    endtask

    task automatic check_weights_model(input string name);
        int mism = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (int'(dut.w_q[i][j]) != mw[i][j]) mism++;
        check(name, mism, 0);
    endtask

    task automatic do_clear(input string name);
        int cnt = 0;
        @(negedge clk); bus.clear_i = 1'b1;
        @(negedge clk); bus.clear_i = 1'b0;
        while (bus.busy_o && cnt < 200) begin cnt++; @(negedge clk); end
        check({name, "_cycles"}, cnt, N);
        model_clear();
    endtask

    task automatic do_learn(input string name, input logic [N-1:0] p);
        int cnt = 0;
        int dones = 0;
        @(negedge clk); bus.learn_valid_i = 1'b1; bus.learn_pattern_i = p;
        @(negedge clk); bus.learn_valid_i = 1'b0;
        check({name, "_ready_low"}, bus.learn_ready_o, 1'b0);
        while (bus.busy_o && cnt < 200) begin
            if (bus.done_o) dones++;
            cnt++; @(negedge clk);
        end
        check({name, "_cycles"}, cnt, N);
        check({name, "_no_done"}, dones, 0);
        model_learn(p);
    endtask

    task automatic do_recall(input string name, input logic [N-1:0] seed, input exp_t e,
                             input int clr_at);
        exp_t got;
        int   cyc  = 1;
        logic seen = 1'b0;
        sb_q.push_back(e);
        @(negedge clk); bus.recall_start_i = 1'b1; bus.recall_seed_i = seed;
        @(negedge clk); bus.recall_start_i = 1'b0;
        while (!seen && cyc < 1000) begin
            if (bus.done_o) seen = 1'b1;
            else begin
                bus.clear_i = (cyc == clr_at);
                @(negedge clk); cyc++;
            end
        end
        bus.clear_i = 1'b0;
        got = sb_q.pop_front();
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL %s_timeout: got no done after %0d cycles, required %0d", name, cyc, got.lat);
        end else begin
            check({name, "_state"}, bus.state_out_o, got.st);
            check({name, "_conv"}, bus.converged_o, got.conv);
            check({name, "_sweeps"}, bus.sweeps_o, got.sw);
            check({name, "_latency"}, cyc, got.lat);
            last_state = got.st;
            @(negedge clk);
            check({name, "_done_pulse"}, {bus.done_o, bus.busy_o, bus.converged_o}, {2'b00, got.conv});
        end
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_ready"}, bus.learn_ready_o, 1'b1);
        check({name, "_busy_done"}, {bus.busy_o, bus.done_o, bus.converged_o}, 3'b000);
        check({name, "_state"}, bus.state_out_o, '0);
        check({name, "_sweeps"}, bus.sweeps_o, 4'd0);
        check_weights_model({name, "_weights"});
    endtask

    initial begin
        exp_t         e;
        logic [N-1:0] pd;
        int           mism;

        vecs[0]  = '{OP_RCL, 25'h1555555, 1'b0, 25'h1555555, 1'b1, 4'd1};
        vecs[1]  = '{OP_LRN, PAT_D,       1'b0, '0,          1'b0, 4'd0};
        vecs[2]  = '{OP_RCL, PAT_D,       1'b0, PAT_D,       1'b1, 4'd1};
        vecs[3]  = '{OP_RCL, D_NOISY,     1'b0, PAT_D,       1'b1, 4'd2};
        vecs[4]  = '{OP_CLR, '0,          1'b0, '0,          1'b0, 4'd0};
        vecs[5]  = '{OP_RCL, D_NOISY,     1'b0, D_NOISY,     1'b1, 4'd1};
        vecs[6]  = '{OP_LRN, PAT_D,       1'b0, '0,          1'b0, 4'd0};
        vecs[7]  = '{OP_LRN, PAT_C,       1'b0, '0,          1'b0, 4'd0};
        vecs[8]  = '{OP_LRN, PAT_J,       1'b0, '0,          1'b0, 4'd0};
        vecs[9]  = '{OP_LRN, PAT_M,       1'b0, '0,          1'b0, 4'd0};
        vecs[10] = '{OP_RCL, D_NOISY,     1'b1, '0,          1'b0, 4'd0};
        vecs[11] = '{OP_RCL, 25'h0F8430B, 1'b1, '0,          1'b0, 4'd0};
        vecs[12] = '{OP_RCL, 25'h1FFFFFF, 1'b1, '0,          1'b0, 4'd0};

        bus.clear_i = 1'b0; bus.learn_valid_i = 1'b0; bus.learn_pattern_i = '0;
        bus.recall_start_i = 1'b0; bus.recall_seed_i = '0;
        last_state = '0;
        model_clear();

        // Reset held for two cycles, then first cycle after release.
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check_reset_state("reset");

        for (int v = 0; v < 13; v++) begin
            case (vecs[v].op)
                OP_CLR: do_clear($sformatf("vec%0d_clear", v));
                OP_LRN: do_learn($sformatf("vec%0d_learn", v), vecs[v].data);
                default: begin
                    if (vecs[v].use_model) model_recall(vecs[v].data, e);
                    else begin
                        e.st = vecs[v].exp_st; e.conv = vecs[v].exp_conv; e.sw = vecs[v].exp_sw;
                        e.lat = recall_latency(int'(vecs[v].exp_sw));
                    end
                    do_recall($sformatf("vec%0d_recall", v), vecs[v].data, e, 0);
                end
            endcase
        end
        check_weights_model("four_pattern_weights");

        // Saturation: one pattern learned ten times.
        do_clear("sat_clear");
        repeat (10) do_learn("sat_learn", PAT_D);
        pd = PAT_D;
        mism = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (int'(dut.w_q[i][j]) != ((i == j) ? 0 : ((pd[i] == pd[j]) ? WLIM : -WLIM))) mism++;
        check("sat_weights", mism, 0);

        // Learn and recall requested together: learn wins; requests while busy are dropped.
        @(negedge clk);
        bus.learn_valid_i = 1'b1; bus.learn_pattern_i = PAT_J;
        bus.recall_start_i = 1'b1; bus.recall_seed_i = 25'h0AAAAAA;
        @(negedge clk);
        bus.recall_start_i = 1'b0; bus.learn_pattern_i = PAT_M;
        check("prio_ready", bus.learn_ready_o, 1'b0);
        check("prio_busy", bus.busy_o, 1'b1);
        check("prio_no_seed", bus.state_out_o, last_state);
        @(negedge clk); bus.learn_valid_i = 1'b0;
        mism = 0;
        for (int c = 0; c < 200 && bus.busy_o; c++) begin
            if (bus.done_o) mism++;
            @(negedge clk);
        end
        check("prio_idle", {bus.busy_o, bus.learn_ready_o}, 2'b01);
        check("prio_no_done", mism, 0);
        model_learn(PAT_J);
        check_weights_model("prio_weights");

        // Clear pulsed mid-recall has no effect.
        model_recall(D_NOISY, e);
        do_recall("clr_in_recall", D_NOISY, e, 5);
        check_weights_model("clr_in_recall_weights");

        // Reset in the middle of a learn wipes every weight.
        @(negedge clk); bus.learn_valid_i = 1'b1; bus.learn_pattern_i = PAT_C;
        @(negedge clk); bus.learn_valid_i = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_clear();
        check_reset_state("reset_mid_learn");
        e.st = PAT_D; e.conv = 1'b1; e.sw = 4'd1; e.lat = recall_latency(1);
        do_recall("post_reset_recall", PAT_D, e, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
